// File: rtl/bus_arbiter.sv
// Two-client (instruction fetch / data) arbiter onto a single memory port.
// Define BUS_ARBITER_RR_EN for round-robin tie-breaking; default is data-first priority.
module bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  // instruction client
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [31:0]       i_data,
  // data client
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [2:0]        d_size,
  input  logic [7:0]        d_strobe,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  // shared memory port
  output logic              m_valid,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_size,
  output logic [7:0]        m_strobe,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e              state_q, state_d;
  logic                owner_data_q, owner_data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic [7:0]          strobe_q, strobe_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                prefer_data;
  logic                grant_data;
  logic                done;

`ifdef BUS_ARBITER_RR_EN
  logic last_data_q, last_data_d;

  // Reset value "data served last" hands the first tie to the instruction client.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_data_q <= 1'b1;
    else        last_data_q <= last_data_d;
  end

  always_comb begin
    prefer_data = !last_data_q;
    last_data_d = last_data_q;
    if (state_q == IDLE && (i_valid || d_valid)) last_data_d = grant_data;
  end
`else
  assign prefer_data = 1'b1;
`endif

  assign grant_data = d_valid && (!i_valid || prefer_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_data_q <= 1'b1;
      addr_q       <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      strobe_q     <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      size_q       <= size_d;
      strobe_q     <= strobe_d;
      wdata_q      <= wdata_d;
    end
  end

  // Request registers load only on acceptance in IDLE and hold otherwise.
  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    addr_d       = addr_q;
    write_d      = write_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (i_valid || d_valid) begin
          state_d      = REQ;
          owner_data_d = grant_data;
          if (grant_data) begin
            addr_d   = d_addr;
            write_d  = |d_strobe;
            size_d   = d_size;
            strobe_d = d_strobe;
            wdata_d  = d_wdata;
          end else begin
            addr_d   = i_addr;
            write_d  = 1'b0;
            size_d   = 3'b010;
            strobe_d = '0;
            wdata_d  = '0;
          end
        end
      end
      REQ:     if (m_ready)  state_d = WAIT;
      WAIT:    if (m_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == WAIT) && m_rvalid;

  assign m_valid  = (state_q == REQ);
  assign m_write  = write_q;
  assign m_addr   = addr_q;
  assign m_size   = size_q;
  assign m_strobe = strobe_q;
  assign m_wdata  = wdata_q;

  assign d_addr_ok = done && owner_data_q;
  assign d_data_ok = done && owner_data_q;
  assign i_addr_ok = done && !owner_data_q;
  assign i_data_ok = done && !owner_data_q;

  // Read data is passed straight through, but forced to zero while reset is held.
  assign d_rdata = reset ? m_rdata : '0;
  assign i_data  = !reset ? 32'h0 : (addr_q[2] ? m_rdata[63:32] : m_rdata[31:0]);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected ok pulses are queued when a request is driven
// and popped when the DUT raises its ok outputs. Honors BUS_ARBITER_RR_EN in the arbitration model.
module tb_bus_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok, i_data_ok;
  logic [31:0]       i_data;
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [7:0]        d_strobe;
  logic [DATA_W-1:0] d_wdata;
  logic              d_addr_ok, d_data_ok;
  logic [DATA_W-1:0] d_rdata;
  logic              m_valid, m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [7:0]        m_strobe;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready, m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  typedef struct {
    logic [3:0]  oks;
    logic [63:0] data;
    bit          checkData;
    bit          isData;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   modelLastData = 1'b1;

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Any ok activity must match the head of the scoreboard; ok activity with nothing queued is an error.
  task automatic sampleOks();
    logic [3:0] oks;
    exp_t       e;
    oks = {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok};
    if (oks != 4'b0000) begin
      if (sb.size() == 0) begin
        checkOutput("okUnexpected", 64'(oks), 64'h0);
      end else begin
        e = sb.pop_front();
        checkOutput("okPattern", 64'(oks), 64'(e.oks));
        if (e.checkData) begin
          if (e.isData) checkOutput("dRdata", d_rdata, e.data);
          else          checkOutput("iData", 64'(i_data), e.data);
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit iv, input bit dv, input logic [63:0] ia, input logic [63:0] da,
                               input logic [7:0] strobe, input logic [2:0] size, input logic [63:0] wdata,
                               input logic [63:0] rdata, input int readyDelay, input int rvalidWait);
    bit          winData;
    logic [63:0] expAddr, expWdata;
    logic        expWrite;
    logic [2:0]  expSize;
    logic [7:0]  expStrobe;
    exp_t        e;
`ifdef BUS_ARBITER_RR_EN
    winData = dv && (!iv || !modelLastData);
`else
    winData = dv;
`endif
    modelLastData = winData;
    if (winData) begin
      expAddr = da; expWrite = |strobe; expSize = size; expStrobe = strobe; expWdata = wdata;
    end else begin
      expAddr = ia; expWrite = 1'b0; expSize = 3'b010; expStrobe = 8'h00; expWdata = 64'h0;
    end

    @(negedge clk);
    i_valid = iv; i_addr = ia; d_valid = dv; d_addr = da;
    d_size = size; d_strobe = strobe; d_wdata = wdata;
    m_ready = 1'b0; m_rvalid = 1'b0;
    #1;
    checkOutput("mValidIdle", 64'(m_valid), 64'h0);
    sampleOks();

    for (int k = 0; k <= readyDelay; k++) begin
      @(negedge clk);
      i_valid = 1'b0; d_valid = 1'b0;
      i_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom};
      d_strobe = 8'($urandom); d_wdata = {$urandom, $urandom}; d_size = 3'($urandom);
      m_ready = (k == readyDelay);
      m_rvalid = (k % 2 == 0);
      m_rdata = {$urandom, $urandom};
      #1;
      checkOutput("mValidReq", 64'(m_valid), 64'h1);
      checkOutput("mAddr", m_addr, expAddr);
      checkOutput("mWrite", 64'(m_write), 64'(expWrite));
      checkOutput("mSize", 64'(m_size), 64'(expSize));
      checkOutput("mStrobe", 64'(m_strobe), 64'(expStrobe));
      checkOutput("mWdata", m_wdata, expWdata);
      sampleOks();
    end

    for (int k = 0; k < rvalidWait; k++) begin
      @(negedge clk);
      m_ready = 1'b0; m_rvalid = 1'b0;
      #1;
      checkOutput("mValidWait", 64'(m_valid), 64'h0);
      sampleOks();
    end

    @(negedge clk);
    m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = rdata;
    e.oks = winData ? 4'b0011 : 4'b1100;
    e.isData = winData;
    e.checkData = !expWrite;
    e.data = winData ? rdata : (expAddr[2] ? {32'h0, rdata[63:32]} : {32'h0, rdata[31:0]});
    sb.push_back(e);
    #1;
    checkOutput("mValidDone", 64'(m_valid), 64'h0);
    sampleOks();
    checkOutput("okSeen", 64'(sb.size()), 64'h0);
    sb.delete();
  endtask

  task automatic resetInWait();
    @(negedge clk);
    d_valid = 1'b1; d_addr = 64'h8000_2000; d_strobe = 8'h00; d_size = 3'b011;
    m_ready = 1'b0; m_rvalid = 1'b0;
    @(negedge clk);
    d_valid = 1'b0; m_ready = 1'b1;
    #1 checkOutput("rstReqValid", 64'(m_valid), 64'h1);
    @(negedge clk);
    m_ready = 1'b0; reset = 1'b0; m_rdata = 64'h5555_6666_7777_8888;
    modelLastData = 1'b1;
    #1;
    checkOutput("rstValid", 64'(m_valid), 64'h0);
    checkOutput("rstOks", 64'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 64'h0);
    checkOutput("rstAddr", m_addr, 64'h0);
    checkOutput("rstRdata", d_rdata, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 sampleOks();
    @(negedge clk);
    m_rvalid = 1'b1;
    #1;
    sampleOks();
    checkOutput("rstLateValid", 64'(m_valid), 64'h0);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    checkOutput("rstIdleValid", 64'(m_valid), 64'h0);
    sampleOks();
  endtask

  initial begin
    bit          iv, dv;
    logic [7:0]  st;
    reset = 1'b0;
    i_valid = 1'b0; i_addr = '0; d_valid = 1'b0; d_addr = '0; d_size = '0; d_strobe = '0; d_wdata = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("resetValid", 64'(m_valid), 64'h0);
    checkOutput("resetOks", 64'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}), 64'h0);
    checkOutput("resetAddr", m_addr, 64'h0);
    checkOutput("resetWrite", 64'(m_write), 64'h0);
    checkOutput("resetRdata", d_rdata, 64'h0);
    checkOutput("resetIData", 64'(i_data), 64'h0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(0, 1, 64'h0, 64'h8000_1000, 8'h00, 3'b011, 64'h0, 64'h1122_3344_5566_7788, 0, 1);
    applyStimulus(0, 1, 64'h0, 64'h8000_1008, 8'h00, 3'b011, 64'h0, 64'h0102_0304_0506_0708, 0, 0);
    applyStimulus(1, 0, 64'h8000_0004, 64'h0, 8'h00, 3'b000, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 1);
    applyStimulus(1, 0, 64'h8000_0000, 64'h0, 8'h00, 3'b000, 64'h0, 64'hAAAA_BBBB_CCCC_DDDD, 1, 0);
    applyStimulus(0, 1, 64'h0, 64'h8000_3000, 8'hFF, 3'b011, 64'hDEAD_BEEF_0000_0000, 64'h0, 3, 1);

    resetInWait();

    for (int n = 0; n < 4; n++)
      applyStimulus(1, 1, 64'h8000_0000 + 64'(n * 8) + 64'h4, 64'h9000_0000 + 64'(n * 8), 8'h00, 3'b011,
                    64'h0, {32'h1000_0000 + 32'(n), 32'h2000_0000 + 32'(n)}, 0, 0);

    for (int n = 0; n < 8; n++) begin
      iv = 1'($urandom_range(0, 1));
      dv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
      st = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      applyStimulus(iv, dv, {32'h8000_0000, $urandom}, {32'h9000_0000, $urandom}, st, 3'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, 64, address width for all ports.
REQ-002 Parameter: DATA_W, 64, memory and data-bus data width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 Ports: i_valid in 1, i_addr in ADDR_W, i_addr_ok out 1, i_data_ok out 1, i_data out 32; instruction-bus client; fetch only.
REQ-006 Ports: d_valid in 1, d_addr in ADDR_W, d_size in 3, d_strobe in 8, d_wdata in DATA_W, d_addr_ok out 1, d_data_ok out 1, d_rdata out DATA_W; data-bus client; d_strobe nonzero = write.
REQ-007 Ports: m_valid out 1, m_write out 1, m_addr out ADDR_W, m_size out 3, m_strobe out 8, m_wdata out DATA_W, m_ready in 1, m_rvalid in 1, m_rdata in DATA_W; single shared memory port.

Function
REQ-008 The FSM SHALL have three states: IDLE, REQ, WAIT.
REQ-009 IDLE: if i_valid or d_valid, the FSM SHALL latch the winning client's request into internal registers, record the owner, and go to REQ next cycle; otherwise it SHALL stay in IDLE.
REQ-010 Default arbitration: d_valid SHALL win over i_valid when both are high in the same IDLE cycle.
REQ-011 REQ: m_valid SHALL be 1 and all m_* request outputs SHALL come from the latched registers; on m_ready=1, go to WAIT.
REQ-012 Instruction requests SHALL drive m_write=0, m_size=3'b010, m_strobe=0.
REQ-013 WAIT: m_valid SHALL be 0; on m_rvalid=1, the owner's addr_ok and data_ok SHALL pulse high for exactly that cycle (combinational from m_rvalid), then go to IDLE.
REQ-014 i_data SHALL equal m_rdata[63:32] when latched i_addr[2]=1, else m_rdata[31:0]; d_rdata SHALL equal m_rdata.
REQ-015 For writes, m_rvalid SHALL serve as the write acknowledge; d_rdata content is don't-care.
REQ-016 Non-owner ok outputs SHALL be 0 in every cycle.
REQ-017 Minimum latency: request seen in IDLE at cycle 0 -> m_valid at cycle 1 -> ok pulse at cycle 2 when m_ready=1 at cycle 1 and m_rvalid=1 at cycle 2.
REQ-018 A client deasserting valid after it was latched SHALL NOT abort the transaction; the transaction completes and the ok pulse is still issued.
REQ-019 A new request SHALL only be accepted in IDLE; back-to-back transactions SHALL therefore have exactly one IDLE cycle between the ok pulse and the next m_valid.
REQ-020 m_rvalid in IDLE or REQ SHALL be ignored.
REQ-021 Request registers SHALL NOT change while the FSM is in REQ or WAIT.

Reset
REQ-022 While reset=0, FSM=IDLE, owner=data, round-robin pointer=data-last (next tie goes to instruction), and all outputs=0 including m_valid and all ok signals.
REQ-023 Reset asserted during REQ or WAIT SHALL abandon the transaction immediately with no ok pulse; a later m_rvalid SHALL be ignored per REQ-020.

Configuration
REQ-024 Macro BUS_ARBITER_RR_EN defined: on a tie in IDLE, the client not served last SHALL win; the last-served pointer updates on each latch.
REQ-025 Macro BUS_ARBITER_RR_EN undefined: fixed priority per REQ-010; no pointer register is instantiated.

Verification
REQ-026 d_valid alone: d_addr=0x80001000, d_strobe=0x00, m_ready=1 immediately, m_rvalid 2 cycles later with m_rdata=0x1122334455667788 -> single d_data_ok pulse, d_rdata=0x1122334455667788, i_* ok stay 0.
REQ-027 i_valid alone: i_addr=0x80000004, m_rdata=0xAAAABBBB_CCCCDDDD -> i_data=0xAAAABBBB; i_addr=0x80000000 -> i_data=0xCCCCDDDD.
REQ-028 i_valid and d_valid high together for 4 transactions: without BUS_ARBITER_RR_EN -> order D,D,D,D before any I; with it -> order I,D,I,D after reset.
REQ-029 Write d_strobe=0xFF, d_wdata=0xDEADBEEF00000000, m_ready held 0 for 3 cycles -> m_valid and m_* fields stable for all 3 cycles; m_write=1; d_data_ok only on m_rvalid.
REQ-030 reset=0 asserted in WAIT, released, then m_rvalid=1 pulse -> no ok pulse on either client, FSM in IDLE, m_valid=0.
